instruction_cache: RTL

Direct-mapped, word-granular instruction cache between the fetch/decode stage and the memory controller's decoder port. It serves aligned instruction-word fetches from an on-chip array with single-cycle hit latency. Misses are forwarded to the memory controller through the same hold-until-ready handshake that the memory controller exposes, and the returned word is filled into the array.

---
 rtl/instruction_cache_pkg.sv | 17 +
 rtl/instruction_cache_array.sv | 48 ++++
 rtl/instruction_cache.sv | 115 +++++++++++
 3 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared parameters, FSM state encoding and address helpers for the instruction cache.
package instruction_cache_pkg;

  localparam int unsigned ICACHE_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MISS     = 2'd1,
    ST_COOLDOWN = 2'd2
  } icache_state_e;

  // Only word-aligned fetches may be held in the array.
  function automatic logic is_cacheable(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_cache_array.sv
// Direct-mapped line storage: valid bits in resettable flops, tag/data in plain
// arrays with a combinational read port and a synchronous write port.
module icache_array
  import instruction_cache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int unsigned TAG_WIDTH   = 32 - INDEX_WIDTH - 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INDEX_WIDTH-1:0] rd_index_i,
  output logic                   rd_valid_o,
  output logic [TAG_WIDTH-1:0]   rd_tag_o,
  output logic [31:0]            rd_data_o,
  input  logic                   wr_en_i,
  input  logic [INDEX_WIDTH-1:0] wr_index_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i,
  input  logic [31:0]            wr_data_i
);

  localparam int unsigned LINES = 32'd1 << INDEX_WIDTH;

  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [31:0]          data_q [LINES];

  // Valid bits: only reset invalidates a line, fills set it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset so they can map onto distributed RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, word-granular instruction cache: single-cycle hits, misses
// forwarded over the memory controller's hold-until-ready handshake.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        fetch_en,
  input  logic [31:0] fetch_addr,
  output logic        fetch_rdy,
  output logic [31:0] fetch_data,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [31:0] mem_data
);

  localparam int unsigned TAG_WIDTH = 32 - INDEX_WIDTH - 2;

  icache_state_e  state_q;
  logic           fetch_rdy_q;
  logic [31:0]    fetch_data_q;
  logic           mem_en_q;
  logic [31:0]    mem_addr_q;

  logic                 rd_valid;
  logic [TAG_WIDTH-1:0] rd_tag;
  logic [31:0]          rd_data;
  logic                 hit;
  logic                 fill_en;

  assign hit = is_cacheable(fetch_addr) && rd_valid &&
               (rd_tag == fetch_addr[31:INDEX_WIDTH+2]);

  // Fill uses the held miss address; a flush in the same cycle suppresses it.
  assign fill_en = !rst_in && rdy_in && !flush && (state_q == ST_MISS) &&
                   mem_rdy && is_cacheable(mem_addr_q);

  icache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_array (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rd_index_i (fetch_addr[INDEX_WIDTH+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill_en),
    .wr_index_i (mem_addr_q[INDEX_WIDTH+1:2]),
    .wr_tag_i   (mem_addr_q[31:INDEX_WIDTH+2]),
    .wr_data_i  (mem_data)
  );

  // Request FSM with registered outputs; flush outranks every transition.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      fetch_rdy_q  <= 1'b0;
      fetch_data_q <= 32'd0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
    end else if (rdy_in) begin
      if (flush) begin
        state_q     <= ST_IDLE;
        fetch_rdy_q <= 1'b0;
        mem_en_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (fetch_en) begin
              if (hit) begin
                fetch_data_q <= rd_data;
                fetch_rdy_q  <= 1'b1;
                state_q      <= ST_COOLDOWN;
              end else begin
                mem_en_q   <= 1'b1;
                mem_addr_q <= fetch_addr;
                state_q    <= ST_MISS;
              end
            end
          end
          ST_MISS: begin
            if (mem_rdy) begin
              fetch_data_q <= mem_data;
              fetch_rdy_q  <= 1'b1;
              mem_en_q     <= 1'b0;
              state_q      <= ST_COOLDOWN;
            end
          end
          // One dead cycle lets the requester retire a request before re-acceptance.
          ST_COOLDOWN: begin
            fetch_rdy_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
          default: begin
            fetch_rdy_q <= 1'b0;
            mem_en_q    <= 1'b0;
            state_q     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign fetch_rdy  = fetch_rdy_q;
  assign fetch_data = fetch_data_q;
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;

endmodule
